// File: rtl/q_seq_ctrl.sv
// q_seq_ctrl: sequencer for one stabilizer-tableau gate update.
//
// A request (start in IDLE) captures two row masks and a rotate count. The sequencer loads Q and
// Q2 from P, streams every tableau row past the Q/Q2 multipliers (only rows whose mask bit is set
// are loaded), then rotates Q and Q2 left by the captured count and pulses done.
//
//   IDLE -> INIT (1) -> SCAN (num_qubit) -> ROTATE (r) -> DONE (1) -> IDLE
//
// Ports
//   clk           single clock, all logic on its rising edge
//   rst_new       synchronous active-high reset
//   start         request a sequence; only honoured in IDLE
//   mask_Q        row k multiplies into Q when bit k is set (captured at start)
//   mask_Q2       row k multiplies into Q2 when bit k is set (captured at start)
//   rotate_amt    left-rotate count for Q/Q2 after the scan (captured at start)
//   row_addr      tableau row read address; data returns one cycle later
//   row_rd_en     qualifies row_addr
//   ld_Q, ld_Q2   load strobes for the Q and Q2 registers
//   load_rotate_Q 0 = parallel load, 1 = rotate left by one
//   load_Q_mux    0 = load from P, 1 = load Q x row product
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse
//
// Every output is a register whose next value is decoded from the next state, next counters and
// the (next) captured masks, so the outputs are glitch-free Moore outputs aligned with the state.

module q_seq_ctrl #(
  parameter int unsigned num_qubit = 4,
  parameter int unsigned RW        = (num_qubit > 1) ? $clog2(num_qubit) : 1,
  localparam int unsigned AW       = (num_qubit > 1) ? $clog2(num_qubit) : 1
) (
  input  logic                 clk,
  input  logic                 rst_new,
  input  logic                 start,
  input  logic [num_qubit-1:0] mask_Q,
  input  logic [num_qubit-1:0] mask_Q2,
  input  logic [RW-1:0]        rotate_amt,
  output logic [AW-1:0]        row_addr,
  output logic                 row_rd_en,
  output logic                 ld_Q,
  output logic                 ld_Q2,
  output logic                 load_rotate_Q,
  output logic                 load_Q_mux,
  output logic                 busy,
  output logic                 done
);

  // Scan index runs 1..num_qubit, so it needs one more value than a row address.
  localparam int unsigned CW = $clog2(num_qubit + 1);

  localparam logic [CW-1:0] KLast  = CW'(num_qubit);
  localparam logic [RW:0]   NqRot  = (RW + 1)'(num_qubit);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StScan,
    StRotate,
    StDone
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // State and captured request
  // ---------------------------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [CW-1:0]          k_q, k_d;
  logic [RW-1:0]          rot_left_q, rot_left_d;
  logic [num_qubit-1:0]   mask_q_q, mask_q_d;
  logic [num_qubit-1:0]   mask_q2_q, mask_q2_d;

  // Registered outputs
  logic [AW-1:0]          row_addr_q, row_addr_d;
  logic                   row_rd_en_q, row_rd_en_d;
  logic                   ld_q_q, ld_q_d;
  logic                   ld_q2_q, ld_q2_d;
  logic                   load_rotate_q, load_rotate_d;
  logic                   load_mux_q, load_mux_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // ---------------------------------------------------------------------------------------------
  // Rotate count reduction: a count of num_qubit or more wraps once (a full rotation is a no-op).
  // ---------------------------------------------------------------------------------------------
  logic [RW:0]   rot_ext;
  logic [RW-1:0] rot_reduced;

  always_comb begin
    rot_ext     = {1'b0, rotate_amt};
    rot_reduced = rotate_amt;
    if (rot_ext >= NqRot) begin
      rot_reduced = RW'(rot_ext - NqRot);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    rot_left_d = rot_left_q;
    mask_q_d   = mask_q_q;
    mask_q2_d  = mask_q2_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StInit;
          mask_q_d   = mask_Q;
          mask_q2_d  = mask_Q2;
          rot_left_d = rot_reduced;
          k_d        = '0;
        end
      end

      StInit: begin
        state_d = StScan;
        k_d     = CW'(1);
      end

      StScan: begin
        if (k_q == KLast) begin
          k_d     = '0;
          state_d = (rot_left_q == '0) ? StDone : StRotate;
        end else begin
          k_d = k_q + CW'(1);
        end
      end

      StRotate: begin
        // rot_left counts the rotate cycles still to issue, including the current one.
        rot_left_d = rot_left_q - RW'(1);
        if (rot_left_q == RW'(1)) begin
          state_d = StDone;
        end
      end

      StDone: begin
        // start is deliberately not looked at here; it must be seen again in IDLE.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Output decode from the next state, so the registered outputs line up with state_q.
  // ---------------------------------------------------------------------------------------------
  logic [AW-1:0] scan_bit;

  always_comb begin
    row_addr_d    = '0;
    row_rd_en_d   = 1'b0;
    ld_q_d        = 1'b0;
    ld_q2_d       = 1'b0;
    load_rotate_d = 1'b0;
    load_mux_d    = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    // Scan cycle k uses mask bit k-1.
    scan_bit      = AW'(k_d - CW'(1));

    unique case (state_d)
      StIdle: begin
        busy_d = 1'b0;
      end

      StInit: begin
        busy_d      = 1'b1;
        ld_q_d      = 1'b1;
        ld_q2_d     = 1'b1;
        row_rd_en_d = 1'b1;
        row_addr_d  = '0;
      end

      StScan: begin
        busy_d     = 1'b1;
        load_mux_d = 1'b1;
        ld_q_d     = mask_q_d[scan_bit];
        ld_q2_d    = mask_q2_d[scan_bit];
        // Prefetch the next row; the last scan cycle only consumes data already in flight.
        if (k_d != KLast) begin
          row_rd_en_d = 1'b1;
          row_addr_d  = AW'(k_d);
        end
      end

      StRotate: begin
        busy_d        = 1'b1;
        ld_q_d        = 1'b1;
        ld_q2_d       = 1'b1;
        load_rotate_d = 1'b1;
      end

      StDone: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end

      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_new) begin
      state_q       <= StIdle;
      k_q           <= '0;
      rot_left_q    <= '0;
      mask_q_q      <= '0;
      mask_q2_q     <= '0;
      row_addr_q    <= '0;
      row_rd_en_q   <= 1'b0;
      ld_q_q        <= 1'b0;
      ld_q2_q       <= 1'b0;
      load_rotate_q <= 1'b0;
      load_mux_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      rot_left_q    <= rot_left_d;
      mask_q_q      <= mask_q_d;
      mask_q2_q     <= mask_q2_d;
      row_addr_q    <= row_addr_d;
      row_rd_en_q   <= row_rd_en_d;
      ld_q_q        <= ld_q_d;
      ld_q2_q       <= ld_q2_d;
      load_rotate_q <= load_rotate_d;
      load_mux_q    <= load_mux_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign row_addr      = row_addr_q;
  assign row_rd_en     = row_rd_en_q;
  assign ld_Q          = ld_q_q;
  assign ld_Q2         = ld_q2_q;
  assign load_rotate_Q = load_rotate_q;
  assign load_Q_mux    = load_mux_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
